// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sizes, the sprite table entry type and the controller
// state encoding used by sprite_table and its testbench.
`timescale 1ns/1ps
package sprite_pkg;

    localparam int NUM_SPRITES = 16;
    localparam int POS_W       = 10;
    localparam int ID_W        = 4;

    // An entry whose id is SPRITE_NONE is a disabled slot.
    localparam logic [ID_W-1:0] SPRITE_NONE = 4'hF;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic [ID_W-1:0]  id;
    } sprite_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_COMMIT = 2'd2
    } sprite_tbl_state_t;

    // Value every table entry takes while reset is asserted.
    localparam sprite_entry_t ENTRY_RESET = '{x: '0, y: '0, id: SPRITE_NONE};

    // Pack a write command into a table entry.
    function automatic sprite_entry_t make_entry(
        input logic [POS_W-1:0] x,
        input logic [POS_W-1:0] y,
        input logic [ID_W-1:0]  id
    );
        sprite_entry_t e;
        e.x  = x;
        e.y  = y;
        e.id = id;
        return e;
    endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// vs_edge_sync: two-flop synchronizer for the VGA vertical sync plus a
// one-cycle pulse on each falling edge of the synchronized level.
// All flops reset to 1 (sync inactive), so releasing reset with VS high
// never produces a spurious edge.
`timescale 1ns/1ps
module vs_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    output logic fall
);

    logic sync_a;
    logic sync_b;
    logic sync_prev;

    // Synchronizer chain and a one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a    <= 1'b1;
            sync_b    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_a    <= vs;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    assign fall = sync_prev & ~sync_b;

endmodule

// File: rtl/sprite_table.sv
// sprite_table: 16-entry sprite attribute table updated by a write port and a
// bulk-clear command, published to the renderer on VS falling edges.
//
// Build option SPRITE_TABLE_DBUF_EN:
//   defined   - writes and clears go to a shadow table; the active (output)
//               table is loaded from the shadow in the single COMMIT cycle
//               that follows a VS falling edge; dirty tracks pending edits.
//   undefined - no shadow table; writes and clears land directly in the
//               active table on their edge; COMMIT only pulses commit_done;
//               dirty is held at 0.
//
// Write handshake: a command transfers on a rising edge where wr_valid and
// wr_ready are both 1. wr_ready is 1 only in IDLE and does not depend on
// wr_valid; the producer must hold the command until it transfers.
`timescale 1ns/1ps
module sprite_table
    import sprite_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    VS,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [3:0]              wr_slot,
    input  logic [POS_W-1:0]        wr_x,
    input  logic [POS_W-1:0]        wr_y,
    input  logic [ID_W-1:0]         wr_id,
    input  logic                    clr_req,
    output logic [POS_W-1:0]        PosX     [0:NUM_SPRITES-1],
    output logic [POS_W-1:0]        PosY     [0:NUM_SPRITES-1],
    output logic [ID_W-1:0]         SpriteID [0:NUM_SPRITES-1],
    output logic                    commit_done,
    output logic                    dirty,
    output logic [1:0]              fsm_state
);

    sprite_tbl_state_t state;
    logic [3:0]        clr_cnt;
    logic              commit_pend;
    logic              vs_fall;
    logic              wr_accept;

    // The active table is the output register itself.
    sprite_entry_t     active [NUM_SPRITES];

`ifdef SPRITE_TABLE_DBUF_EN
    sprite_entry_t     shadow [NUM_SPRITES];
    logic              dirty_q;
`endif

    vs_edge_sync u_vs_sync (
        .clk   (Clk),
        .rst_n (Reset_n),
        .vs    (VS),
        .fall  (vs_fall)
    );

    assign wr_ready  = (state == ST_IDLE);
    assign wr_accept = wr_valid && wr_ready;
    assign fsm_state = state;

    // Controller: pending-commit latch, clear sweep counter, commit pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            clr_cnt     <= 4'd0;
            commit_pend <= 1'b0;
            commit_done <= 1'b0;
`ifdef SPRITE_TABLE_DBUF_EN
            dirty_q     <= 1'b0;
`endif
        end else begin
            commit_done <= 1'b0;
            // Any number of VS edges before the commit collapse into this flag.
            if (vs_fall) begin
                commit_pend <= 1'b1;
            end
`ifdef SPRITE_TABLE_DBUF_EN
            if (wr_accept) begin
                dirty_q <= 1'b1;
            end
`endif
            case (state)
                ST_IDLE: begin
                    // A pending commit wins over a clear in the same cycle;
                    // the clear request is dropped.
                    if (commit_pend) begin
                        state <= ST_COMMIT;
                    end else if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= 4'd0;
                    end
                end
                ST_CLEAR: begin
`ifdef SPRITE_TABLE_DBUF_EN
                    dirty_q <= 1'b1;
`endif
                    clr_cnt <= clr_cnt + 4'd1;
                    if (clr_cnt == 4'd15) begin
                        state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    commit_done <= 1'b1;
                    // An edge arriving in the commit cycle itself belongs to
                    // the next frame, so it stays pending.
                    if (!vs_fall) begin
                        commit_pend <= 1'b0;
                    end
`ifdef SPRITE_TABLE_DBUF_EN
                    dirty_q <= 1'b0;
`endif
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPRITE_TABLE_DBUF_EN
    assign dirty = dirty_q;

    // Shadow edits from writes and the clear sweep; active loads on COMMIT.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow[i] <= ENTRY_RESET;
                active[i] <= ENTRY_RESET;
            end
        end else begin
            // Writes are only accepted in IDLE and the sweep only runs in
            // CLEAR, so the two never target the shadow in the same cycle.
            if (wr_accept) begin
                shadow[wr_slot] <= make_entry(wr_x, wr_y, wr_id);
            end
            if (state == ST_CLEAR) begin
                shadow[clr_cnt].id <= SPRITE_NONE;
            end
            if (state == ST_COMMIT) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end
`else
    assign dirty = 1'b0;

    // Single-buffered: writes and the clear sweep edit the active table.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                active[i] <= ENTRY_RESET;
            end
        end else begin
            if (wr_accept) begin
                active[wr_slot] <= make_entry(wr_x, wr_y, wr_id);
            end
            if (state == ST_CLEAR) begin
                active[clr_cnt].id <= SPRITE_NONE;
            end
        end
    end
`endif

    // Output ports are plain views of the active table fields.
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_out
        assign PosX[g]     = active[g].x;
        assign PosY[g]     = active[g].y;
        assign SpriteID[g] = active[g].id;
    end

endmodule

// File: tb/tb_sprite_table.sv
// tb_sprite_table: directed + randomized bench for sprite_table with a
// table-level reference model (shadow/active arrays updated per command).
`timescale 1ns/1ps
module tb_sprite_table;
  import sprite_pkg::*;

`ifdef SPRITE_TABLE_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic        Clk;
  logic        Reset_n;
  logic        VS;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_slot;
  logic [9:0]  wr_x;
  logic [9:0]  wr_y;
  logic [3:0]  wr_id;
  logic        clr_req;
  logic [9:0]  PosX     [0:15];
  logic [9:0]  PosY     [0:15];
  logic [3:0]  SpriteID [0:15];
  logic        commit_done;
  logic        dirty;
  logic [1:0]  fsm_state;

  sprite_table dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .VS          (VS),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_slot     (wr_slot),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_id       (wr_id),
    .clr_req     (clr_req),
    .PosX        (PosX),
    .PosY        (PosY),
    .SpriteID    (SpriteID),
    .commit_done (commit_done),
    .dirty       (dirty),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [9:0] m_sx [16];
  logic [9:0] m_sy [16];
  logic [3:0] m_sid [16];
  logic [9:0] m_ax [16];
  logic [9:0] m_ay [16];
  logic [3:0] m_aid [16];
  logic       m_dirty;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_sx[i] = '0; m_sy[i] = '0; m_sid[i] = 4'hF;
      m_ax[i] = '0; m_ay[i] = '0; m_aid[i] = 4'hF;
    end
    m_dirty = 1'b0;
  endfunction

  function automatic void m_write(input logic [3:0] s, input logic [9:0] x,
                                  input logic [9:0] y, input logic [3:0] id);
    if (DBUF) begin
      m_sx[s] = x; m_sy[s] = y; m_sid[s] = id; m_dirty = 1'b1;
    end else begin
      m_ax[s] = x; m_ay[s] = y; m_aid[s] = id;
    end
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) begin
      if (DBUF) m_sid[i] = 4'hF;
      else m_aid[i] = 4'hF;
    end
    m_dirty = DBUF;
  endfunction

  function automatic void m_commit();
    if (DBUF) begin
      for (int i = 0; i < 16; i++) begin
        m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_aid[i] = m_sid[i];
      end
    end
    m_dirty = 1'b0;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_table(input string tag);
    logic [23:0] e;
    for (int i = 0; i < 16; i++) exp_q.push_back({m_ax[i], m_ay[i], m_aid[i]});
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, i), 32'({PosX[i], PosY[i], SpriteID[i]}), 32'(e));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    repeat (n) @(negedge Clk);
  endtask

  task automatic write(input logic [3:0] s, input logic [9:0] x,
                       input logic [9:0] y, input logic [3:0] id);
    check("wr_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1; wr_slot = s; wr_x = x; wr_y = y; wr_id = id;
    @(negedge Clk);
    m_write(s, x, y, id);
  endtask

  task automatic write_rand();
    logic [3:0] s;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] id;
    s  = 4'($urandom_range(0, 15));
    x  = 10'($urandom_range(0, 1023));
    y  = 10'($urandom_range(0, 1023));
    id = 4'($urandom_range(0, 15));
    write(s, x, y, id);
  endtask

  // VS falling edge; optionally a write placed in the cycle the synchronized
  // edge is seen. Outputs must hold until the single commit_done pulse.
  task automatic vsync(input bit with_wr, input logic [3:0] s, input logic [9:0] x,
                       input logic [9:0] y, input logic [3:0] id);
    int seen;
    seen = 0;
    VS = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (with_wr && k == 3) begin
        m_write(s, x, y, id);
        wr_valid = 1'b0;
      end
      if (commit_done === 1'b1) begin
        seen++;
        if (seen == 1) m_commit();
        check_table("vs_commit");
        check("vs_dirty", 32'(dirty), 32'(m_dirty));
      end else begin
        check_table("vs_hold");
      end
      if (with_wr && k == 2) begin
        check("vs_wr_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1; wr_slot = s; wr_x = x; wr_y = y; wr_id = id;
      end
    end
    check("vs_pulses", 32'(seen), 32'd1);
    VS = 1'b1;
    idle(4);
  endtask

  // Clear sweep. vs_at >= 0 drops VS in that CLEAR cycle; rst_at >= 0 pulses
  // reset in that CLEAR cycle. A repeated clr_req mid-sweep must be ignored.
  task automatic clear_seq(input int vs_at, input int rst_at);
    int low;
    int seen;
    low = 0;
    seen = 0;
    check("clr_ready_before", 32'(wr_ready), 32'd1);
    clr_req = 1'b1;
    @(negedge Clk);
    clr_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == rst_at) begin
        Reset_n = 1'b0;
        #1;
        m_reset();
        check_table("rst_mid_clear");
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        check("rst_done", 32'(commit_done), 32'd0);
        check("rst_dirty", 32'(dirty), 32'(m_dirty));
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
          @(negedge Clk);
          if (commit_done === 1'b1) seen++;
        end
        check("rst_no_commit", 32'(seen), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd1);
        check("rst_state_after", 32'(fsm_state), 32'(ST_IDLE));
        check_table("rst_after");
        return;
      end
      if (wr_ready === 1'b1) break;
      low++;
      if (commit_done === 1'b1) seen++;
      if (k == vs_at) VS = 1'b0;
      clr_req = (k == 3);
      @(negedge Clk);
    end
    clr_req = 1'b0;
    check("clr_ready_low", 32'(low), 32'd16);
    m_clear();
    check_table("clr_done");
    check("clr_dirty", 32'(dirty), 32'(m_dirty));
    if (vs_at >= 0) begin
      for (int j = 0; j < 12; j++) begin
        @(negedge Clk);
        if (commit_done === 1'b1) begin
          seen++;
          if (seen == 1) m_commit();
          check_table("clr_vs_commit");
        end
      end
      check("clr_vs_pulses", 32'(seen), 32'd1);
      check("clr_vs_dirty", 32'(dirty), 32'(m_dirty));
      VS = 1'b1;
      idle(4);
    end else begin
      check("clr_no_commit", 32'(seen), 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset_n = 1'b0; VS = 1'b1; wr_valid = 1'b0; clr_req = 1'b0;
    wr_slot = '0; wr_x = '0; wr_y = '0; wr_id = '0;
    m_reset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Reset state
    check_table("reset");
    check("reset_ready", 32'(wr_ready), 32'd1);
    check("reset_dirty", 32'(dirty), 32'd0);
    check("reset_done", 32'(commit_done), 32'd0);
    check("reset_state", 32'(fsm_state), 32'(ST_IDLE));

    // Single write to slot 3, then a frame commit
    write(4'd3, 10'd100, 10'd50, 4'd2);
    idle(1);
    check_table("wr3_pre");
    check("wr3_dirty", 32'(dirty), 32'(m_dirty));
    vsync(1'b0, '0, '0, '0, '0);
    check("slot3_id", 32'(SpriteID[3]), 32'd2);
    check("slot3_x", 32'(PosX[3]), 32'd100);
    check("slot3_y", 32'(PosY[3]), 32'd50);
    check("slot3_dirty", 32'(dirty), 32'd0);

    // Clear, then commit: ids disabled, positions retained
    write(4'd9, 10'd777, 10'd333, 4'd6);
    idle(1);
    clear_seq(-1, -1);
    vsync(1'b0, '0, '0, '0, '0);
    check("clr_slot3_x", 32'(PosX[3]), 32'd100);
    check("clr_slot9_id", 32'(SpriteID[9]), 32'd15);

    // VS edge during CLEAR cycle 5: one commit right after the sweep
    write(4'd1, 10'd12, 10'd34, 4'd5);
    idle(1);
    clear_seq(5, -1);

    // Write landing with the synchronized VS edge is part of that commit
    vsync(1'b1, 4'd7, 10'd321, 10'd123, 4'd4);
    check("slot7_id", 32'(SpriteID[7]), 32'd4);

    // Back-to-back writes to one slot: last wins
    write(4'd5, 10'd1, 10'd2, 4'd3);
    write(4'd5, 10'd900, 10'd901, 4'd8);
    idle(1);
    vsync(1'b0, '0, '0, '0, '0);
    check("slot5_last_id", 32'(SpriteID[5]), 32'd8);

    // Randomized bursts with random gaps, each followed by a commit
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(3, 8);
      for (int w = 0; w < n; w++) begin
        write_rand();
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(1);
      check_table("rand_pre");
      check("rand_dirty", 32'(dirty), 32'(m_dirty));
      vsync(1'b0, '0, '0, '0, '0);
    end

    // Reset during CLEAR cycle 8 aborts the sweep with no commit afterwards
    write_rand();
    idle(1);
    clear_seq(-1, 8);

    idle(2);
    check_table("final");
    check("final_dirty", 32'(dirty), 32'(m_dirty));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
